// File: rtl/if_fetch_bridge.sv
// ============================================================================
// Module   : if_fetch_bridge
// Purpose  : Instruction-fetch bridge from the PC register to an SRAM-like
//            bus, one outstanding read. Optional IF_ADEL_CHECK_EN adds the
//            misaligned-fetch check and the inst_adel flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module if_fetch_bridge (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc_in,
   input  logic        flush,
   input  logic        id_ready,
   output logic [31:0] inst_out,
   output logic [31:0] inst_pc,
   output logic        inst_valid,
   output logic        wait_stop,
   output logic        inst_req,
   output logic [31:0] inst_addr,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic [31:0] inst_rdata
`ifdef IF_ADEL_CHECK_EN
   ,
   output logic        inst_adel
`endif
);

   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_REQ  = 3'd1;
   localparam logic [2:0] S_WAIT = 3'd2;
   localparam logic [2:0] S_HOLD = 3'd3;
   localparam logic [2:0] S_DROP = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [31:0] req_pc_q, req_pc_d;
   logic [31:0] inst_out_q, inst_out_d;
   logic [31:0] inst_pc_q, inst_pc_d;
   logic        valid_q, valid_d;
   logic        adel_q, adel_d;
   logic        w_misaligned;

`ifdef IF_ADEL_CHECK_EN
   assign w_misaligned = (pc_in[1:0] != 2'b00);
   assign inst_adel    = adel_q;
`else
   assign w_misaligned = 1'b0;
`endif

   assign inst_req   = (state_q == S_REQ) && !w_misaligned;
   assign inst_addr  = pc_in;
   assign wait_stop  = !(((state_q == S_HOLD) && id_ready) || flush);
   assign inst_out   = inst_out_q;
   assign inst_pc    = inst_pc_q;
   assign inst_valid = valid_q;

   always_comb begin
      state_d    = state_q;
      req_pc_d   = req_pc_q;
      inst_out_d = inst_out_q;
      inst_pc_d  = inst_pc_q;
      adel_d     = adel_q;
      case (state_q)
         S_IDLE: state_d = S_REQ;
         S_REQ: begin
            if (w_misaligned) begin
               // Misaligned fetch skips the bus and presents a nop with the fault flag
               if (!flush) begin
                  state_d    = S_HOLD;
                  inst_out_d = 32'd0;
                  inst_pc_d  = pc_in;
                  adel_d     = 1'b1;
               end
            end else if (inst_addr_ok) begin
               req_pc_d = pc_in;
               state_d  = flush ? S_DROP : S_WAIT;
            end
         end
         S_WAIT: begin
            if (flush) begin
               state_d = inst_data_ok ? S_REQ : S_DROP;
            end else if (inst_data_ok) begin
               inst_out_d = inst_rdata;
               inst_pc_d  = req_pc_q;
               state_d    = S_HOLD;
            end
         end
         S_HOLD: begin
            if (id_ready || flush) state_d = S_REQ;
         end
         S_DROP: begin
            if (inst_data_ok) state_d = S_REQ;
         end
         default: state_d = S_IDLE;
      endcase
      if (state_d != S_HOLD) adel_d = 1'b0;
      valid_d = (state_d == S_HOLD);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         req_pc_q   <= 32'd0;
         inst_out_q <= 32'd0;
         inst_pc_q  <= 32'd0;
         valid_q    <= 1'b0;
         adel_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         req_pc_q   <= req_pc_d;
         inst_out_q <= inst_out_d;
         inst_pc_q  <= inst_pc_d;
         valid_q    <= valid_d;
         adel_q     <= adel_d;
      end
   end

endmodule

`default_nettype wire

// File: doc/if_fetch_bridge.md
# if_fetch_bridge

Instruction-fetch bus bridge between the PC register and the instruction SRAM-like bus. It consumes the fetch address the PC stage produces and issues one read per address. It returns the instruction word to the ID stage and drives `wait_stop` back to the PC register, so the PC advances only when the current fetch has been delivered or a redirect occurs. At most one bus transaction is outstanding; a flush discards an in-flight response.

## Interface
- No parameters.
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `pc_in`  in  32  current fetch address from the PC register.
- `flush`  in  1  redirect/kill: the current fetch is abandoned and the PC register loads a new target at this edge.
- `id_ready`  in  1  ID stage accepts `inst_out` this cycle.
- `inst_out`  out  32  fetched instruction word.
- `inst_pc`  out  32  address `inst_out` was fetched from.
- `inst_valid`  out  1  `inst_out`/`inst_pc` valid.
- `wait_stop`  out  1  holds the PC register when high.
- `inst_req`  out  1  bus read request.
- `inst_addr`  out  32  bus address.
- `inst_addr_ok`  in  1  bus accepted the request.
- `inst_data_ok`  in  1  bus returns data.
- `inst_rdata`  in  32  bus read data.
- `inst_adel`  out  1  misaligned-fetch exception flag; present only with `IF_ADEL_CHECK_EN`.

## Operation
- The FSM has five states: IDLE, REQ, WAIT, HOLD, DROP.
- **IDLE:** entered on reset. Moves to REQ the next cycle unconditionally.
- **REQ:**
  - `inst_req`=1 and `inst_addr`=`pc_in` (combinational).
  - On `inst_addr_ok`, latch `pc_in` into `req_pc` and move to WAIT; otherwise stay.
  - With flush and no `addr_ok`: stay in REQ. `inst_addr` follows the new `pc_in` next cycle.
  - With flush and `addr_ok` in the same cycle: go to DROP.
- **WAIT:**
  - On `inst_data_ok`, latch `inst_rdata` into `inst_out` and `req_pc` into `inst_pc`, then go to HOLD.
  - On flush: go to DROP. If `data_ok` arrives in the same cycle as the flush, discard the data and go to REQ.
- **HOLD:**
  - `inst_valid`=1.
  - On `id_ready`, or on flush, go to REQ.
  - `inst_out` and `inst_pc` keep their values until the next capture.
- **DROP:** on `inst_data_ok`, discard the data and go to REQ. `inst_valid`=0.
- `wait_stop` = NOT((HOLD AND `id_ready`) OR `flush`). It is combinational.
- `inst_data_ok` in IDLE, REQ or HOLD is ignored; the bus never produces it there.
- Reset wins over every other event and forces IDLE from any state. The bus resets on the same reset, so no stale response follows.

## Timing
- Reset values:
  - state = IDLE, `inst_req`=0, `inst_valid`=0, `wait_stop`=1.
  - `inst_out`=0, `inst_pc`=0, `inst_adel`=0.
- Best-case latency with `addr_ok` in the REQ cycle and `data_ok` one cycle later:
  - `inst_valid` rises 2 edges after REQ is entered.
  - Back-to-back fetch throughput is one instruction per 3 cycles: REQ, WAIT, HOLD.
- `inst_req` stays high from REQ entry until `addr_ok`. `inst_addr` may change while waiting only because of a flush.
- `inst_valid` and `inst_out` are registered outputs. `inst_req`, `inst_addr` and `wait_stop` are combinational from state and inputs.
- Flush takes effect at the same edge; no instruction from the flushed path is ever presented with `inst_valid`=1.

## Configuration
- **`IF_ADEL_CHECK_EN` defined:**
  - In REQ, if `pc_in[1:0]`≠0, no request is issued (`inst_req`=0).
  - Next edge goes to HOLD with `inst_out`=0 (nop), `inst_pc`=`pc_in` and `inst_adel`=1.
  - `inst_adel` clears when HOLD is left.
- **`IF_ADEL_CHECK_EN` undefined:**
  - The `inst_adel` port is absent.
  - Addresses are issued unmodified regardless of alignment.

## Test plan
- **Basic fetch:** release reset with `pc_in`=0xBFC00000, `addr_ok` immediate, `data_ok` one cycle later with rdata=0x24080001, `id_ready`=1. Required: `inst_valid` with `inst_out`=0x24080001 and `inst_pc`=0xBFC00000; `wait_stop` low exactly in the HOLD cycle.
- **Bus stall:** hold `addr_ok` low for 4 cycles. Required: `inst_req` held high with a stable `inst_addr` and `wait_stop`=1 throughout; a single transaction is issued.
- **ID backpressure:** `id_ready`=0 for 3 cycles in HOLD. Required: `inst_out` stable, `wait_stop`=1, no new `inst_req` until `id_ready`=1.
- **Flush in WAIT:** flush one cycle before `data_ok` (rdata=0xDEADBEEF), new `pc_in`=0xBFC00380. Required: 0xDEADBEEF is never valid; the next request has `inst_addr`=0xBFC00380.
- **Flush coincident with data_ok, and reset in WAIT:**
  - Flush in the same cycle as `data_ok`: the data is dropped and the FSM returns straight to REQ.
  - Reset asserted in WAIT: all outputs return to reset values on the next edge.
- **Misaligned fetch (`IF_ADEL_CHECK_EN` defined):** `pc_in`=0xBFC00002. Required: no `inst_req`; `inst_adel`=1, `inst_out`=0 and `inst_pc`=0xBFC00002 in HOLD.
